// File: rtl/spi_reg_arbiter.sv
// PWM configuration register bank with round-robin arbitration between SPI frames and a local write port.
// Optional macro SHADOW_UPDATE_EN: commits go to shadow registers, outputs reload on update_strobe.
module spi_reg_arbiter #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_valid,
  input  logic              spi_wr,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_data,
  output logic              spi_ready,
  input  logic              loc_valid,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_data,
  output logic              loc_ready,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
`ifdef SHADOW_UPDATE_EN
  input  logic              update_strobe,
`endif
  output logic              commit_pulse,
  output logic              err_pulse,
  output logic              err_src
);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;
  localparam logic SRC_SPI = 1'b0;
  localparam logic SRC_LOC = 1'b1;

  logic              spi_full_r, spi_wr_r;
  logic [ADDR_W-1:0] spi_addr_r;
  logic [DATA_W-1:0] spi_data_r;
  logic              loc_full_r;
  logic [ADDR_W-1:0] loc_addr_r;
  logic [DATA_W-1:0] loc_data_r;

  state_t state_r, state_nx_s;
  logic   sel_r, sel_nx_s, last_grant_r;

  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              wr_bit_s, commit_s, drop_s, clr_spi_s, clr_loc_s;

  logic [DATA_W-1:0] bank_r    [NUM_REGS];
  logic [DATA_W-1:0] bank_nx_s [NUM_REGS];
  logic [DATA_W-1:0] out_s     [NUM_REGS];

  logic commit_pulse_r, err_pulse_r, err_src_r;

  // Holding buffers: a full buffer blocks acceptance, so a clear and a refill never share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_full_r <= 1'b0;
      spi_wr_r   <= 1'b0;
      spi_addr_r <= '0;
      spi_data_r <= '0;
      loc_full_r <= 1'b0;
      loc_addr_r <= '0;
      loc_data_r <= '0;
    end else begin
      if (clr_spi_s) begin
        spi_full_r <= 1'b0;
      end else if (spi_valid && !spi_full_r) begin
        spi_full_r <= 1'b1;
        spi_wr_r   <= spi_wr;
        spi_addr_r <= spi_addr;
        spi_data_r <= spi_data;
      end
      if (clr_loc_s) begin
        loc_full_r <= 1'b0;
      end else if (loc_valid && !loc_full_r) begin
        loc_full_r <= 1'b1;
        loc_addr_r <= loc_addr;
        loc_data_r <= loc_data;
      end
    end
  end

  // FSM state register, including the grant selection and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      sel_r        <= SRC_SPI;
      last_grant_r <= SRC_LOC;
    end else begin
      state_r <= state_nx_s;
      sel_r   <= sel_nx_s;
      if (state_r == WRITE) begin
        last_grant_r <= sel_r;
      end
    end
  end

  // Next-state logic: when both buffers are full the source not granted last wins.
  always_comb begin
    state_nx_s = state_r;
    sel_nx_s   = sel_r;
    case (state_r)
      IDLE: begin
        if (spi_full_r && loc_full_r) begin
          sel_nx_s   = ~last_grant_r;
          state_nx_s = WRITE;
        end else if (spi_full_r) begin
          sel_nx_s   = SRC_SPI;
          state_nx_s = WRITE;
        end else if (loc_full_r) begin
          sel_nx_s   = SRC_LOC;
          state_nx_s = WRITE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WRITE:   state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output logic: in WRITE, route the selected buffer and classify the write as commit or drop.
  always_comb begin
    wr_addr_s = '0;
    wr_data_s = '0;
    wr_bit_s  = 1'b0;
    commit_s  = 1'b0;
    drop_s    = 1'b0;
    clr_spi_s = 1'b0;
    clr_loc_s = 1'b0;
    case (state_r)
      WRITE: begin
        if (sel_r == SRC_LOC) begin
          wr_addr_s = loc_addr_r;
          wr_data_s = loc_data_r;
          wr_bit_s  = 1'b1;
          clr_loc_s = 1'b1;
        end else begin
          wr_addr_s = spi_addr_r;
          wr_data_s = spi_data_r;
          wr_bit_s  = spi_wr_r;
          clr_spi_s = 1'b1;
        end
        if (wr_bit_s && (wr_addr_s < ADDR_W'(NUM_REGS))) begin
          commit_s = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end
      default: begin
        commit_s = 1'b0;
        drop_s   = 1'b0;
      end
    endcase
  end

  // Next value of the register bank after a possible commit.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit_s && (wr_addr_s == ADDR_W'(i))) begin
        bank_nx_s[i] = wr_data_s;
      end else begin
        bank_nx_s[i] = bank_r[i];
      end
    end
  end

  // Register bank (the shadow copy when shadow updates are enabled).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_r[i] <= bank_nx_s[i];
      end
    end
  end

`ifdef SHADOW_UPDATE_EN
  logic [DATA_W-1:0] live_r [NUM_REGS];

  // Live outputs reload from the shadows; a coincident commit is taken on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live_r[i] <= '0;
      end
    end else if (update_strobe) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live_r[i] <= bank_nx_s[i];
      end
    end
  end

  assign out_s = live_r;
`else
  assign out_s = bank_r;
`endif

  // Status pulses; err_src keeps the source of the most recent drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pulse_r <= 1'b0;
      err_pulse_r    <= 1'b0;
      err_src_r      <= 1'b0;
    end else begin
      commit_pulse_r <= commit_s;
      err_pulse_r    <= drop_s;
      if (drop_s) begin
        err_src_r <= sel_r;
      end
    end
  end

  assign spi_ready       = ~spi_full_r;
  assign loc_ready       = ~loc_full_r;
  assign en_reg_out_7_0  = out_s[0];
  assign en_reg_out_15_8 = out_s[1];
  assign en_reg_pwm_7_0  = out_s[2];
  assign en_reg_pwm_15_8 = out_s[3];
  assign pwm_duty_cycle  = out_s[4];
  assign commit_pulse    = commit_pulse_r;
  assign err_pulse       = err_pulse_r;
  assign err_src         = err_src_r;

endmodule

// File: doc/spi_reg_arbiter.md
Name: spi_reg_arbiter

Overview:
Owns the PWM configuration register bank and arbitrates writes into it. There are two requesters: the decoded SPI frame stream from the SPI peripheral, and an on-chip local write port used by test and bring-up logic. Each requester has a one-entry holding buffer. A round-robin two-state FSM commits one write every two cycles. Invalid writes are dropped and flagged.

Parameters:
NUM_REGS, 5, number of implemented registers at addresses 0..NUM_REGS-1
ADDR_W, 7, address field width
DATA_W, 8, data and register width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
spi_valid  input  1  SPI frame available
spi_wr  input  1  frame R/W bit; 1 = write
spi_addr  input  ADDR_W  frame address
spi_data  input  DATA_W  frame data
spi_ready  output  1  SPI holding buffer empty
loc_valid  input  1  local write request
loc_addr  input  ADDR_W  local address
loc_data  input  DATA_W  local data
loc_ready  output  1  local holding buffer empty
en_reg_out_7_0  output  DATA_W  register 0
en_reg_out_15_8  output  DATA_W  register 1
en_reg_pwm_7_0  output  DATA_W  register 2
en_reg_pwm_15_8  output  DATA_W  register 3
pwm_duty_cycle  output  DATA_W  register 4
commit_pulse  output  1  one-cycle pulse when a valid write lands
err_pulse  output  1  one-cycle pulse when a write is dropped
err_src  output  1  source of the last dropped write; 0 = SPI, 1 = local; held until the next drop

Behaviour:
- Reset: clk is the clock; rst_n is the reset, asynchronous and active-low. On reset, all registers are 0, both buffers are empty, FSM is in IDLE, last_grant = LOCAL, and commit_pulse, err_pulse and err_src are 0. spi_ready and loc_ready read 1 after reset.
- Handshake: x_ready = buffer x empty. A write is accepted on an edge where x_valid & x_ready.
  - The buffer captures addr, data and wr. The local port stores wr = 1.
  - The buffer is not refilled on the edge that clears it. Ready rises the cycle after the clear.
- Valid must be held until accepted. Changes to addr or data while not ready are ignored.
- FSM IDLE:
  - If neither buffer is full, stay in IDLE.
  - If exactly one buffer is full, set sel to that source and go to WRITE.
  - If both are full, sel = the source that is not last_grant, then go to WRITE.
- FSM WRITE (always exactly 1 cycle), on the exiting edge:
  - Clear the sel buffer and set last_grant = sel.
  - If wr = 1 and addr < NUM_REGS: write data to register[addr] and pulse commit_pulse.
  - Otherwise: no register change, pulse err_pulse, err_src = sel.
  - Return to IDLE.
- Latency: acceptance on edge E0; FSM enters WRITE on E1; register output changes on E2.
  - commit_pulse and err_pulse are high in the cycle after E2.
  - Sustained throughput is one write per 2 cycles. Both requesters saturated alternate strictly.
- A request arriving while the other source is in WRITE waits in its buffer and is served next.
- Address arithmetic: unsigned compare on the full ADDR_W bits. Address 127 is invalid. No wrap-around.
- Registers hold their value indefinitely between writes. Only the WRITE state modifies them.
- Reset mid-WRITE: write discarded, all state returns to reset values immediately.

Optional Feature:
SHADOW_UPDATE_EN
- Defined:
  - Adds input port update_strobe (1 bit, after pwm_duty_cycle).
  - Commits write shadow registers; outputs load all shadows on an edge with update_strobe = 1. This gives glitch-free PWM reconfiguration at period boundaries.
  - If a commit and update_strobe coincide, the output takes the newly committed value on that edge.
  - Shadows reset to 0.
  - commit_pulse still marks the shadow write.
- Undefined: no update_strobe port; commits write the outputs directly, as above.

Test Plan:
- Reset, then one SPI write (wr=1, addr=4, data=0x80) -> spi_ready low 1 cycle after acceptance; pwm_duty_cycle=0x80 two edges after acceptance; commit_pulse 1 cycle; other registers 0.
- SPI (addr 0, 0xF0) and local (addr 0, 0x0F) accepted on the same edge -> SPI wins first (last_grant=LOCAL); en_reg_out_7_0 goes 0xF0 then 0x0F two cycles later.
- Invalid writes: SPI addr=5 data=0xAA; SPI wr=0 addr=1; local addr=127 -> three err_pulses; err_src = 0, 0, 1; all registers unchanged.
- Both ports saturated with 8 writes each to addr 2 -> grants alternate SPI/LOCAL; a write lands every 2 cycles; 16 commit_pulses; final value equals the last granted write.
- Assert rst_n low during WRITE of addr 3 = 0x55 -> en_reg_pwm_15_8 stays 0; buffers empty; ready high after release.
- With SHADOW_UPDATE_EN: write addr 1 = 0x3C -> output stays 0 until update_strobe pulses, then reads 0x3C; commit coincident with strobe -> new value appears on that edge.
